// File: rtl/sram_responder.sv
// sram_responder: on-chip SRAM stand-in for the CPU's active-low strobe bus, with one I/O word for switches and the HEX display
module sram_responder #(
    parameter int          ADDR_W  = 10,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_CE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic [15:0] HEX_out,
    output logic        Rd_done,
    output logic        Wr_done
);
    typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, HOLD} state_t;
    state_t r_state, w_next;
    logic [15:0] r_addr, r_wdata;
    logic r_ub, r_lb, r_is_wr;
    logic [15:0] r_mem [0:(1 << ADDR_W) - 1] = '{default: 16'h0000};
    logic w_wr_req, w_rd_req, w_is_io, w_commit;
    logic [ADDR_W-1:0] w_idx;
    logic [15:0] w_raw, w_rd_word;
    assign w_wr_req  = !Mem_CE && !Mem_WE;
    assign w_rd_req  = !Mem_CE && !Mem_OE && Mem_WE;
    assign w_is_io   = r_addr == IO_ADDR;
    assign w_idx     = r_addr[ADDR_W-1:0];
    assign w_raw     = w_is_io ? Switches : r_mem[w_idx];
    assign w_rd_word = {r_ub ? 8'h00 : w_raw[15:8], r_lb ? 8'h00 : w_raw[7:0]};
    assign w_commit  = r_state == WR2 && !Reset;
    // state register
    always_ff @(posedge Clk)
        r_state <= Reset ? IDLE : w_next;
    // next-state: accept requests only in IDLE, park in HOLD until the originating strobe releases
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_wr_req ? WR1 : w_rd_req ? RD1 : IDLE;
            RD1:     w_next = (!Mem_CE && !Mem_OE) ? RD2 : IDLE;
            RD2:     w_next = HOLD;
            WR1:     w_next = (!Mem_CE && !Mem_WE) ? WR2 : IDLE;
            WR2:     w_next = HOLD;
            HOLD:    w_next = (!Mem_CE && (r_is_wr ? !Mem_WE : !Mem_OE)) ? HOLD : IDLE;
            default: w_next = IDLE;
        endcase
    end
    // handshake pulses decoded from state
    always_comb begin
        Rd_done = r_state == RD2;
        Wr_done = r_state == WR2;
    end
    // capture the request so later strobe/address changes cannot disturb the access
    always_ff @(posedge Clk)
        if (r_state == IDLE && (w_wr_req || w_rd_req)) begin
            r_addr  <= ADDR;
            r_wdata <= Data_from_CPU;
            r_ub    <= Mem_UB;
            r_lb    <= Mem_LB;
            r_is_wr <= w_wr_req;
        end
    // read data register, loaded only when RD1 sees the strobe still asserted
    always_ff @(posedge Clk)
        if (Reset)
            Data_to_CPU <= 16'h0000;
        else if (r_state == RD1 && !Mem_CE && !Mem_OE)
            Data_to_CPU <= w_rd_word;
    // HEX display register, byte-lane write at the I/O address
    always_ff @(posedge Clk)
        if (Reset)
            HEX_out <= 16'h0000;
        else if (w_commit && w_is_io) begin
            if (!r_ub) HEX_out[15:8] <= r_wdata[15:8];
            if (!r_lb) HEX_out[7:0]  <= r_wdata[7:0];
        end
    // storage array, byte-lane write; never touched for the I/O address
    always_ff @(posedge Clk)
        if (w_commit && !w_is_io) begin
            if (!r_ub) r_mem[w_idx][15:8] <= r_wdata[15:8];
            if (!r_lb) r_mem[w_idx][7:0]  <= r_wdata[7:0];
        end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed bus transactions against sram_responder with hand-computed expectations
module tb_sram_responder;
    logic Clk = 0, Reset = 1;
    logic Mem_CE = 1, Mem_UB = 1, Mem_LB = 1, Mem_OE = 1, Mem_WE = 1;
    logic [15:0] ADDR = 0, Data_from_CPU = 0, Switches = 0;
    logic [15:0] Data_to_CPU, HEX_out;
    logic Rd_done, Wr_done;
    int checks = 0, failures = 0, rd_cnt = 0, wr_cnt = 0;
    logic [15:0] rd_cap = 0;

    sram_responder dut (
        .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
        .Switches(Switches), .Data_to_CPU(Data_to_CPU), .HEX_out(HEX_out),
        .Rd_done(Rd_done), .Wr_done(Wr_done)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Rd_done) begin
            rd_cnt++;
            rd_cap = Data_to_CPU;
        end
        if (Wr_done) wr_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic oe, input logic we,
                       input logic ub, input logic lb, input int cyc);
        @(negedge Clk);
        rd_cnt = 0;
        wr_cnt = 0;
        ADDR = a;
        Data_from_CPU = d;
        Mem_CE = 0;
        Mem_OE = oe;
        Mem_WE = we;
        Mem_UB = ub;
        Mem_LB = lb;
        repeat (cyc) @(negedge Clk);
        Mem_CE = 1;
        Mem_OE = 1;
        Mem_WE = 1;
        Mem_UB = 1;
        Mem_LB = 1;
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_data", Data_to_CPU, 16'h0000);
        check("rst_hex", HEX_out, 16'h0000);
        check("rst_rd_done", {15'b0, Rd_done}, 16'h0000);
        check("rst_wr_done", {15'b0, Wr_done}, 16'h0000);
        Reset = 0;

        bus(16'h0005, 16'h1234, 1, 0, 0, 0, 2);
        check("wr_full_cnt", 16'(wr_cnt), 16'd1);
        bus(16'h0005, 16'h0000, 0, 1, 0, 0, 2);
        check("rd_full_cnt", 16'(rd_cnt), 16'd1);
        check("rd_full_cap", rd_cap, 16'h1234);
        check("rd_full_data", Data_to_CPU, 16'h1234);

        bus(16'h0005, 16'hABCD, 1, 0, 1, 0, 2);
        check("wr_lb_cnt", 16'(wr_cnt), 16'd1);
        bus(16'h0005, 16'h0000, 0, 1, 0, 0, 2);
        check("rd_merged", Data_to_CPU, 16'h12CD);
        bus(16'h0005, 16'h0000, 0, 1, 0, 1, 2);
        check("rd_ub_only", Data_to_CPU, 16'h1200);

        Switches = 16'h00F0;
        bus(16'hFFFF, 16'h0000, 0, 1, 0, 0, 2);
        check("rd_switches", Data_to_CPU, 16'h00F0);
        bus(16'hFFFF, 16'hBEEF, 1, 0, 0, 0, 2);
        check("hex_write", HEX_out, 16'hBEEF);
        bus(16'h03FF, 16'h0000, 0, 1, 0, 0, 2);
        check("rd_3ff_untouched", Data_to_CPU, 16'h0000);
        bus(16'hFFFF, 16'h0000, 1, 0, 0, 1, 2);
        check("hex_ub_lane", HEX_out, 16'h00EF);

        bus(16'h0007, 16'h5555, 1, 0, 0, 0, 1);
        check("abort_wr_cnt", 16'(wr_cnt), 16'd0);
        bus(16'h0007, 16'h0000, 0, 1, 0, 0, 2);
        check("abort_wr_word", Data_to_CPU, 16'h0000);
        bus(16'h0005, 16'h0000, 0, 1, 0, 0, 1);
        check("abort_rd_cnt", 16'(rd_cnt), 16'd0);
        check("abort_rd_data", Data_to_CPU, 16'h0000);

        bus(16'h0009, 16'h4242, 0, 0, 0, 0, 4);
        check("prio_wr_cnt", 16'(wr_cnt), 16'd1);
        check("prio_rd_cnt", 16'(rd_cnt), 16'd0);
        bus(16'h0009, 16'h0000, 0, 1, 0, 0, 2);
        check("prio_word", Data_to_CPU, 16'h4242);
        bus(16'h0009, 16'hFFFF, 1, 0, 1, 1, 2);
        check("nolane_wr_cnt", 16'(wr_cnt), 16'd1);
        bus(16'h0009, 16'h0000, 0, 1, 0, 0, 2);
        check("nolane_word", Data_to_CPU, 16'h4242);
        bus(16'h0005, 16'h0000, 0, 1, 0, 0, 5);
        check("hold_rd_cnt", 16'(rd_cnt), 16'd1);
        check("hold_rd_data", Data_to_CPU, 16'h12CD);

        @(negedge Clk);
        wr_cnt = 0;
        ADDR = 16'hFFFF;
        Data_from_CPU = 16'h1111;
        Mem_CE = 0;
        Mem_WE = 0;
        Mem_UB = 0;
        Mem_LB = 0;
        @(negedge Clk);
        Reset = 1;
        @(negedge Clk);
        Reset = 0;
        Mem_CE = 1;
        Mem_WE = 1;
        Mem_UB = 1;
        Mem_LB = 1;
        repeat (3) @(negedge Clk);
        check("rstmid_hex", HEX_out, 16'h0000);
        check("rstmid_wr_cnt", 16'(wr_cnt), 16'd0);
        check("rstmid_data", Data_to_CPU, 16'h0000);
        bus(16'h0005, 16'h0000, 0, 1, 0, 0, 2);
        check("rstmid_array_kept", Data_to_CPU, 16'h12CD);

        bus(16'h0405, 16'h7777, 1, 0, 0, 0, 2);
        bus(16'h0005, 16'h0000, 0, 1, 0, 0, 2);
        check("alias_word", Data_to_CPU, 16'h7777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
